// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline register and the ALU decoder.
// ALU control codes, alu_op encodings and R-type funct values live here so the ALU can reuse them.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_ORI   = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] store_data;
    logic [4:0]  wr_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        illegal;
  } ex_regs_t;

  localparam ex_regs_t EX_BUBBLE = '{
    valid:      1'b0,
    alu_ctrl:   ALU_NOP,
    alu_in1:    32'd0,
    alu_in2:    32'd0,
    store_data: 32'd0,
    wr_reg:     5'd0,
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    illegal:    1'b0
  };

  // or-immediate is a logical op, so its immediate is zero-extended; everything else sign-extends
  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic [1:0] alu_op);
    logic [31:0] ext;
    if (alu_op == OP_ORI) begin
      ext = {16'd0, imm};
    end else begin
      ext = {{16{imm[15]}}, imm};
    end
    return ext;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX handshake/bus bundle; master is the decode side, slave is the ID/EX stage.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm;
  logic        alu_src;
  logic        reg_dst;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;

  logic        load_use_hazard;
  logic        ex_valid;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_ctrl;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_wr_reg;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_illegal;

  modport master (
    output stall, flush, in_valid, alu_op, funct, rs_addr, rt_addr, rd_addr,
           rs_data, rt_data, imm, alu_src, reg_dst, reg_write, mem_read,
           mem_write, mem_to_reg,
    input  load_use_hazard, ex_valid, alu_in1, alu_in2, alu_ctrl, ex_store_data,
           ex_wr_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_illegal
  );

  modport slave (
    input  stall, flush, in_valid, alu_op, funct, rs_addr, rt_addr, rd_addr,
           rs_data, rt_data, imm, alu_src, reg_dst, reg_write, mem_read,
           mem_write, mem_to_reg,
    output load_use_hazard, ex_valid, alu_in1, alu_in2, alu_ctrl, ex_store_data,
           ex_wr_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_illegal
  );

endinterface

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// Combinational ALU control decoder: (alu_op, funct) -> alu_ctrl code plus unsupported-funct flag.
module alu_ctrl_dec
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  // Unknown R-type functions decode to NOP and raise illegal so EX can squash side effects
  always_comb begin
    alu_ctrl = ALU_NOP;
    illegal  = 1'b0;
    case (alu_op)
      OP_ADD: alu_ctrl = ALU_ADD;
      OP_SUB: alu_ctrl = ALU_SUB;
      OP_ORI: alu_ctrl = ALU_OR;
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: begin
            alu_ctrl = ALU_NOP;
            illegal  = 1'b1;
          end
        endcase
      end
      default: begin
        alu_ctrl = ALU_NOP;
        illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand selection, ALU control decode and load-use hazard detection.
// Only load_use_hazard is combinational; every EX-side output comes straight from ex_q.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int HAZARD_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [15:0] imm,
  input  logic        alu_src,
  input  logic        reg_dst,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  output logic        load_use_hazard,
  output logic        ex_valid,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_wr_reg,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_illegal
);

  ex_regs_t    ex_q;
  ex_regs_t    ex_d;
  ex_regs_t    load_s;
  logic [3:0]  dec_ctrl_s;
  logic        dec_illegal_s;
  logic        hazard_raw_s;
  logic        rt_read_s;

  alu_ctrl_dec u_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (dec_ctrl_s),
    .illegal  (dec_illegal_s)
  );

  // rt is a source for register-register ops and as store data, not when it is an I-type destination
  assign rt_read_s    = !alu_src || mem_write;
  assign hazard_raw_s = in_valid && ex_q.valid && ex_q.mem_read && (ex_q.wr_reg != 5'd0) &&
                        ((ex_q.wr_reg == rs_addr) || ((ex_q.wr_reg == rt_addr) && rt_read_s));
  assign load_use_hazard = (HAZARD_EN != 0) ? hazard_raw_s : 1'b0;

  // Register image for a normal load of the current ID instruction
  always_comb begin
    load_s            = EX_BUBBLE;
    load_s.valid      = 1'b1;
    load_s.alu_ctrl   = dec_ctrl_s;
    load_s.illegal    = dec_illegal_s;
    load_s.alu_in1    = rs_data;
    load_s.alu_in2    = alu_src ? ext_imm(imm, alu_op) : rt_data;
    load_s.store_data = rt_data;
    load_s.wr_reg     = reg_dst ? rd_addr : rt_addr;
    load_s.reg_write  = reg_write && !dec_illegal_s;
    load_s.mem_read   = mem_read && !dec_illegal_s;
    load_s.mem_write  = mem_write && !dec_illegal_s;
    load_s.mem_to_reg = mem_to_reg;
  end

  // Next-state priority: flush, then stall (hold), then hazard or empty slot (bubble), then load
  always_comb begin
    ex_d = EX_BUBBLE;
    if (flush) begin
      ex_d = EX_BUBBLE;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (load_use_hazard || !in_valid) begin
      ex_d = EX_BUBBLE;
    end else begin
      ex_d = load_s;
    end
  end

  // Pipeline register; synchronous reset discards anything held by a stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign alu_in1       = ex_q.alu_in1;
  assign alu_in2       = ex_q.alu_in2;
  assign alu_ctrl      = ex_q.alu_ctrl;
  assign ex_store_data = ex_q.store_data;
  assign ex_wr_reg     = ex_q.wr_reg;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized run against a reference model.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if bus();

  id_ex_stage #(.HAZARD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .stall(bus.stall), .flush(bus.flush), .in_valid(bus.in_valid),
    .alu_op(bus.alu_op), .funct(bus.funct), .rs_addr(bus.rs_addr), .rt_addr(bus.rt_addr),
    .rd_addr(bus.rd_addr), .rs_data(bus.rs_data), .rt_data(bus.rt_data), .imm(bus.imm),
    .alu_src(bus.alu_src), .reg_dst(bus.reg_dst), .reg_write(bus.reg_write),
    .mem_read(bus.mem_read), .mem_write(bus.mem_write), .mem_to_reg(bus.mem_to_reg),
    .load_use_hazard(bus.load_use_hazard), .ex_valid(bus.ex_valid), .alu_in1(bus.alu_in1),
    .alu_in2(bus.alu_in2), .alu_ctrl(bus.alu_ctrl), .ex_store_data(bus.ex_store_data),
    .ex_wr_reg(bus.ex_wr_reg), .ex_reg_write(bus.ex_reg_write), .ex_mem_read(bus.ex_mem_read),
    .ex_mem_write(bus.ex_mem_write), .ex_mem_to_reg(bus.ex_mem_to_reg), .ex_illegal(bus.ex_illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        valid;
    logic [3:0]  ctrl;
    logic [31:0] in1, in2, sd;
    logic [4:0]  wr;
    logic        rw, mr, mw, m2r, ill;
  } exp_t;

  exp_t m;
  int   rtype_tbl[int];

  function automatic logic [110:0] dut_vec();
    return {bus.ex_valid, bus.alu_ctrl, bus.alu_in1, bus.alu_in2, bus.ex_store_data, bus.ex_wr_reg,
            bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg, bus.ex_illegal};
  endfunction

  function automatic exp_t bubble();
    exp_t b = '0;
    b.ctrl = 4'hF;
    return b;
  endfunction

  // A valid load in EX whose nonzero destination is a source of the ID instruction
  function automatic bit model_hazard();
    bit uses_rt = !bus.alu_src || bus.mem_write;
    return bus.in_valid && m.valid && m.mr && (m.wr != 5'd0) &&
           ((m.wr == bus.rs_addr) || (uses_rt && (m.wr == bus.rt_addr)));
  endfunction

  function automatic exp_t model_next();
    exp_t n;
    int   immv;
    if (!rst_n || bus.flush) return bubble();
    if (bus.stall) return m;
    if (model_hazard() || !bus.in_valid) return bubble();
    n = '0;
    n.valid = 1'b1;
    immv = int'(bus.imm);
    if (bus.alu_op != 2'd3 && immv >= 32768) immv = immv - 65536;
    n.in1 = bus.rs_data;
    n.in2 = bus.alu_src ? 32'(immv) : bus.rt_data;
    n.sd  = bus.rt_data;
    n.wr  = bus.reg_dst ? bus.rd_addr : bus.rt_addr;
    n.rw  = bus.reg_write;
    n.mr  = bus.mem_read;
    n.mw  = bus.mem_write;
    n.m2r = bus.mem_to_reg;
    case (bus.alu_op)
      2'd0: n.ctrl = 4'd2;
      2'd1: n.ctrl = 4'd6;
      2'd3: n.ctrl = 4'd1;
      default: begin
        if (rtype_tbl.exists(int'(bus.funct))) begin
          n.ctrl = 4'(rtype_tbl[int'(bus.funct)]);
        end else begin
          n.ctrl = 4'hF;
          n.ill  = 1'b1;
          n.rw   = 1'b0;
          n.mr   = 1'b0;
          n.mw   = 1'b0;
        end
      end
    endcase
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.alu_op = 2'd0; bus.funct = 6'd0;
    bus.rs_addr = 5'd0; bus.rt_addr = 5'd0; bus.rd_addr = 5'd0; bus.rs_data = 32'd0;
    bus.rt_data = 32'd0; bus.imm = 16'd0; bus.alu_src = 1'b0; bus.reg_dst = 1'b0;
    bus.reg_write = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_to_reg = 1'b0;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [15:0] im, input logic src,
                       input logic dst, input logic rw, input logic mr, input logic mw);
    bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b1;
    bus.alu_op = op; bus.funct = fn; bus.rs_addr = rs; bus.rt_addr = rt; bus.rd_addr = rd;
    bus.rs_data = rsd; bus.rt_data = rtd; bus.imm = im; bus.alu_src = src; bus.reg_dst = dst;
    bus.reg_write = rw; bus.mem_read = mr; bus.mem_write = mw; bus.mem_to_reg = mr;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    tick();
    tick();
    n_tests++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.ex_valid); end
    n_tests++; if (bus.alu_ctrl !== 4'hF) begin n_fail++; $display("FAIL reset_ctrl got %h want f", bus.alu_ctrl); end
    n_tests++; if (dut_vec() !== 111'(bubble())) begin n_fail++; $display("FAIL reset_all got %h want %h", dut_vec(), bubble()); end
    n_tests++; if (bus.load_use_hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %0b want 0", bus.load_use_hazard); end
  endtask

  task automatic test_rtype_add();
    rst_n = 1'b1;
    drive(2'b10, 6'b100000, 5'd1, 5'd9, 5'd3, 32'd5, 32'd7, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    n_tests++;
    if ({bus.alu_in1, bus.alu_in2, bus.alu_ctrl, bus.ex_wr_reg, bus.ex_valid} !== {32'd5, 32'd7, 4'b0010, 5'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL rtype_add got in1=%0d in2=%0d ctrl=%b wr=%0d v=%0b want 5 7 0010 3 1",
               bus.alu_in1, bus.alu_in2, bus.alu_ctrl, bus.ex_wr_reg, bus.ex_valid);
    end
    bus.in_valid = 1'b0;
    tick();
    n_tests++; if (dut_vec() !== 111'(bubble())) begin n_fail++; $display("FAIL invalid_bubble got %h want %h", dut_vec(), bubble()); end
  endtask

  task automatic test_immediates();
    drive(2'b00, 6'd0, 5'd1, 5'd4, 5'd0, 32'd100, 32'd0, 16'hFFFC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    n_tests++; if ({bus.alu_in2, bus.alu_ctrl} !== {32'hFFFFFFFC, 4'b0010}) begin n_fail++; $display("FAIL lw_imm got %h/%b want fffffffc/0010", bus.alu_in2, bus.alu_ctrl); end
    drive(2'b11, 6'd0, 5'd2, 5'd5, 5'd0, 32'd0, 32'd0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    n_tests++; if (bus.load_use_hazard !== 1'b0) begin n_fail++; $display("FAIL ori_no_hazard got %0b want 0", bus.load_use_hazard); end
    tick();
    n_tests++; if ({bus.alu_in2, bus.alu_ctrl} !== {32'h00008000, 4'b0001}) begin n_fail++; $display("FAIL ori_imm got %h/%b want 00008000/0001", bus.alu_in2, bus.alu_ctrl); end
  endtask

  task automatic test_load_use();
    drive(2'b00, 6'd0, 5'd1, 5'd4, 5'd0, 32'd0, 32'd0, 16'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(2'b10, 6'b100000, 5'd4, 5'd5, 5'd6, 32'd11, 32'd22, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    n_tests++; if (bus.load_use_hazard !== 1'b1) begin n_fail++; $display("FAIL lu_rs_hazard got %0b want 1", bus.load_use_hazard); end
    tick();
    n_tests++; if ({bus.ex_valid, bus.alu_ctrl, bus.load_use_hazard} !== {1'b0, 4'hF, 1'b0}) begin n_fail++; $display("FAIL lu_bubble got v=%0b ctrl=%h hz=%0b want 0 f 0", bus.ex_valid, bus.alu_ctrl, bus.load_use_hazard); end
    tick();
    n_tests++; if ({bus.ex_valid, bus.ex_wr_reg, bus.alu_in1} !== {1'b1, 5'd6, 32'd11}) begin n_fail++; $display("FAIL lu_dependent got v=%0b wr=%0d in1=%0d want 1 6 11", bus.ex_valid, bus.ex_wr_reg, bus.alu_in1); end
    drive(2'b00, 6'd0, 5'd1, 5'd4, 5'd0, 32'd0, 32'd0, 16'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(2'b00, 6'd0, 5'd7, 5'd4, 5'd0, 32'd0, 32'd0, 16'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    n_tests++; if (bus.load_use_hazard !== 1'b0) begin n_fail++; $display("FAIL lu_rt_imm got %0b want 0", bus.load_use_hazard); end
    bus.mem_write = 1'b1; bus.mem_read = 1'b0; bus.reg_write = 1'b0;
    #1;
    n_tests++; if (bus.load_use_hazard !== 1'b1) begin n_fail++; $display("FAIL lu_rt_store got %0b want 1", bus.load_use_hazard); end
    drive(2'b00, 6'd0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 16'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(2'b10, 6'b100000, 5'd0, 5'd0, 5'd6, 32'd1, 32'd2, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    n_tests++; if (bus.load_use_hazard !== 1'b0) begin n_fail++; $display("FAIL lu_r0 got %0b want 0", bus.load_use_hazard); end
  endtask

  task automatic test_priority();
    drive(2'b10, 6'b100000, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(2'b10, 6'b100010, 5'd8, 5'd9, 5'd10, 32'hDEAD, 32'hBEEF, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({bus.ex_valid, bus.alu_in1, bus.alu_in2, bus.alu_ctrl, bus.ex_wr_reg} !== {1'b1, 32'h100, 32'h200, 4'b0010, 5'd3}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got v=%0b in1=%h in2=%h ctrl=%b wr=%0d", i, bus.ex_valid, bus.alu_in1, bus.alu_in2, bus.alu_ctrl, bus.ex_wr_reg);
      end
    end
    bus.flush = 1'b1;
    tick();
    n_tests++; if (dut_vec() !== 111'(bubble())) begin n_fail++; $display("FAIL stall_flush got %h want %h", dut_vec(), bubble()); end
    drive(2'b00, 6'd0, 5'd1, 5'd4, 5'd0, 32'd0, 32'd0, 16'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(2'b10, 6'b100000, 5'd4, 5'd5, 5'd6, 32'd11, 32'd22, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.stall = 1'b1;
    tick();
    n_tests++; if ({bus.ex_mem_read, bus.ex_wr_reg, bus.load_use_hazard} !== {1'b1, 5'd4, 1'b1}) begin n_fail++; $display("FAIL stall_hazard got mr=%0b wr=%0d hz=%0b want 1 4 1", bus.ex_mem_read, bus.ex_wr_reg, bus.load_use_hazard); end
    bus.stall = 1'b0;
    tick();
    n_tests++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL hazard_after_stall got %0b want 0", bus.ex_valid); end
    tick();
    n_tests++; if ({bus.ex_valid, bus.ex_wr_reg} !== {1'b1, 5'd6}) begin n_fail++; $display("FAIL dep_after_stall got v=%0b wr=%0d want 1 6", bus.ex_valid, bus.ex_wr_reg); end
  endtask

  task automatic test_illegal();
    drive(2'b10, 6'b000000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    n_tests++;
    if ({bus.alu_ctrl, bus.ex_illegal, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_valid} !== {4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal got ctrl=%h ill=%0b rw=%0b v=%0b want f 1 0 1", bus.alu_ctrl, bus.ex_illegal, bus.ex_reg_write, bus.ex_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(2'b10, 6'b100101, 5'd1, 5'd2, 5'd3, 32'h55, 32'h66, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    bus.stall = 1'b1;
    tick();
    n_tests++; if (bus.alu_in1 !== 32'h55) begin n_fail++; $display("FAIL pre_reset_hold got %h want 55", bus.alu_in1); end
    rst_n = 1'b0;
    tick();
    n_tests++; if (dut_vec() !== 111'(bubble())) begin n_fail++; $display("FAIL reset_mid_stall got %h want %h", dut_vec(), bubble()); end
    rst_n = 1'b1;
    drive(2'b10, 6'b101010, 5'd1, 5'd2, 5'd3, 32'h77, 32'h88, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    n_tests++; if ({bus.ex_valid, bus.alu_in1, bus.alu_ctrl} !== {1'b1, 32'h77, 4'b0111}) begin n_fail++; $display("FAIL post_reset_load got v=%0b in1=%h ctrl=%b want 1 77 0111", bus.ex_valid, bus.alu_in1, bus.alu_ctrl); end
  endtask

  task automatic test_random();
    logic [5:0] legal_fn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    bit         hz_exp;
    set_idle();
    rst_n = 1'b0;
    tick();
    m = bubble();
    for (int i = 0; i < 600; i++) begin
      rst_n         = ($urandom_range(63) != 0);
      bus.stall     = ($urandom_range(7) == 0);
      bus.flush     = ($urandom_range(15) == 0);
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.alu_op    = 2'($urandom_range(3));
      bus.funct     = ($urandom_range(3) != 0) ? legal_fn[$urandom_range(4)] : 6'($urandom);
      bus.rs_addr   = 5'($urandom_range(3));
      bus.rt_addr   = 5'($urandom_range(3));
      bus.rd_addr   = 5'($urandom_range(3));
      bus.rs_data   = $urandom;
      bus.rt_data   = $urandom;
      bus.imm       = 16'($urandom);
      bus.alu_src   = 1'($urandom);
      bus.reg_dst   = 1'($urandom);
      bus.reg_write = 1'($urandom);
      bus.mem_read  = 1'($urandom);
      bus.mem_write = 1'($urandom);
      bus.mem_to_reg = 1'($urandom);
      #1;
      hz_exp = model_hazard();
      n_tests++; if (bus.load_use_hazard !== hz_exp) begin n_fail++; $display("FAIL rand_hazard[%0d] got %0b want %0b", i, bus.load_use_hazard, hz_exp); end
      m = model_next();
      tick();
      n_tests++; if (dut_vec() !== 111'(m)) begin n_fail++; $display("FAIL rand_state[%0d] got %h want %h", i, dut_vec(), m); end
    end
  endtask

  initial begin
    rtype_tbl[32] = 2;
    rtype_tbl[34] = 6;
    rtype_tbl[36] = 0;
    rtype_tbl[37] = 1;
    rtype_tbl[42] = 7;
    test_reset();
    test_rtype_add();
    test_immediates();
    test_load_use();
    test_priority();
    test_illegal();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter HAZARD_EN, default 1, enabling internal load-use detection (0: detection disabled; load_use_hazard tied 0).
REQ-002 SHALL have ports, one per line, in this order:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
stall  in  1  downstream hold request
flush  in  1  insert bubble (branch/jump squash)
in_valid  in  1  ID instruction valid
alu_op  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type by funct, 11 or-immediate
funct  in  6  R-type function field
rs_addr, rt_addr, rd_addr  in  5 each  register specifiers
rs_data, rt_data  in  32 each  register file read data
imm  in  16  instruction immediate
alu_src  in  1  1 selects extended immediate as operand 2
reg_dst  in  1  1 selects rd_addr as destination, else rt_addr
reg_write, mem_read, mem_write, mem_to_reg  in  1 each  ID control bits
load_use_hazard  out  1  combinational; upstream must hold PC and IF/ID
ex_valid  out  1  EX slot valid
alu_in1, alu_in2  out  32 each  ALU operands
alu_ctrl  out  4  ALU control code
ex_store_data  out  32  registered rt_data for stores
ex_wr_reg  out  5  destination register
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered controls
ex_illegal  out  1  registered unsupported-funct flag

Function
REQ-003 alu_ctrl codes SHALL be AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOP 1111.
REQ-004 Decode: alu_op 00 -> ADD; 01 -> SUB; 11 -> OR; 10 -> funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
REQ-005 alu_op 10 with any other funct SHALL register alu_ctrl NOP, ex_illegal 1, ex_reg_write/ex_mem_read/ex_mem_write 0, ex_valid 1.
REQ-006 Immediate SHALL be sign-extended for alu_op 00/01/10, zero-extended for alu_op 11.
REQ-007 alu_in1 SHALL be registered rs_data; alu_in2 registered extended imm if alu_src else rt_data.
REQ-008 ex_wr_reg SHALL be rd_addr if reg_dst else rt_addr.
REQ-009 load_use_hazard SHALL be 1 iff HAZARD_EN & in_valid & ex_valid & ex_mem_read & ex_wr_reg!=0 & (ex_wr_reg==rs_addr | (ex_wr_reg==rt_addr & (!alu_src | mem_write))).
REQ-010 Per-edge priority SHALL be: reset > flush > stall > hazard > load.
REQ-011 flush SHALL register a bubble regardless of stall or hazard.
REQ-012 stall (no flush) SHALL hold every output register unchanged; load_use_hazard still evaluates from held state.
REQ-013 hazard (no flush, no stall) SHALL register a bubble; the held ID instruction loads on the following edge once hazard clears.
REQ-014 Bubble SHALL be: ex_valid 0, alu_ctrl NOP, all ex_ control bits 0, ex_illegal 0, data/address outputs 0.
REQ-015 in_valid 0 on a load edge SHALL register a bubble.
REQ-016 Latency SHALL be one cycle ID input -> EX output; throughput one instruction per cycle absent stall/hazard.
REQ-017 No combinational path SHALL exist from inputs to outputs other than load_use_hazard.

Reset
REQ-018 rst_n low at a rising edge SHALL load the bubble state of REQ-014 into all registers, overriding flush/stall.
REQ-019 Reset mid-stall SHALL discard held instruction; first post-reset edge with in_valid loads normally.

Structure
REQ-020 Shared package SHALL hold the alu_ctrl codes, alu_op encodings and funct constants, reused by the ALU.
REQ-021 Decode SHALL be a combinational sub-module alu_ctrl_dec (alu_op, funct -> alu_ctrl, illegal).

Verification
REQ-022 R-type add: alu_op 10, funct 100000, rs_data 5, rt_data 7, reg_dst 1, rd 3 -> next cycle alu_in1 5, alu_in2 7, alu_ctrl 0010, ex_wr_reg 3, ex_valid 1.
REQ-023 Immediates: lw imm 0xFFFC, alu_src 1 -> alu_in2 0xFFFFFFFC, ADD; alu_op 11 imm 0x8000 -> alu_in2 0x00008000, OR.
REQ-024 Load-use: lw to r4 in EX, next ID uses rs 4 -> load_use_hazard 1, bubble registered, dependent instruction in EX one cycle later; rt 4 with alu_src 1 and mem_write 0 -> no hazard; destination r0 -> no hazard.
REQ-025 Priority: stall+flush same edge -> bubble; stall 3 cycles -> outputs constant; stall with active hazard -> held state, hazard stays 1.
REQ-026 Illegal funct 000000 -> alu_ctrl 1111, ex_illegal 1, ex_reg_write 0; rst_n low mid-stall -> all outputs bubble next edge.
